board_seed_sequencer: RTL and testbench
=======================================

// Module: board_seed_sequencer
// PURPOSE
//  Upstream stage of the 16x16 life engine. Loads a seed board row-by-row over a
//  valid/ready stream and holds it as a flat 256-bit board for the engine.
//  Issues engine step pulses, either free-running at a programmable period or
//  single-stepped on request.
// PARAMETERS
//  ROWS        16      board height; also the number of rows per load
//  COLS        16      board width; also the row_data width
//  STEP_CYCLES 25_000_000  clock cycles between steps in RUN (>=2)
// PORTS
//  clk          in   1        system clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  load_start   in   1        pulse: begin loading a new seed
//  row_valid    in   1        row_data holds a valid row
//  row_ready    out  1        sequencer accepts a row this cycle
//  row_data     in   COLS     seed row; bit j = column j
//  run          in   1        level: free-run stepping while high
//  single_step  in   1        pulse: one step while idle
//  board_out    out  ROWS*COLS  seed board; cell (i,j) = bit i*COLS+j
//  step_en      out  1        one-cycle engine step pulse
//  load_done    out  1        one-cycle pulse after the last row is accepted
//  busy         out  1        high in LOAD or RUN
// BEHAVIOUR
//  Reset: state=IDLE, board_out=0, row_idx=0, timer=STEP_CYCLES-1; all other outputs 0.
//  FSM states:
//   IDLE
//    - load_start -> LOAD (highest priority).
//    - Else run -> RUN.
//    - Else single_step -> step_en=1 on the next cycle; state stays IDLE.
//   LOAD
//    - row_ready=1. A row is accepted on the cycle row_valid && row_ready.
//    - On accept: board_out[row_idx*COLS +: COLS] <= row_data and row_idx++.
//    - Accepting row ROWS-1: row_idx<=0, load_done=1 next cycle, -> IDLE.
//    - run, single_step and a repeated load_start are ignored in LOAD.
//    - Rows not yet written keep their old values. board_out is not cleared on load_start.
//   RUN
//    - Timer decrements every cycle. At 0: step_en=1 for one cycle and timer reloads STEP_CYCLES-1.
//    - First pulse comes STEP_CYCLES cycles after entering RUN.
//    - run low -> IDLE and timer reloads. No pulse is issued on the exit cycle.
//    - load_start -> LOAD (aborts the run) and timer reloads.
//  - Handshake: row_ready is a registered function of state only, never of row_valid.
//  - step_en never asserts in LOAD. Consecutive step_en pulses are >=STEP_CYCLES apart in RUN.
//  - Timer width is $clog2(STEP_CYCLES). row_idx width is $clog2(ROWS). No overflow is possible.
//  - Reset mid-LOAD discards the partial load and clears board_out.
// CONFIGURATION
//  RANDOM_SEED_EN defined:
//   - Adds input rand_fill (pulse, honoured in IDLE only, below load_start).
//   - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) runs every cycle.
//   - rand_fill enters LOAD with an internal source: one row per cycle from the LFSR's
//     low COLS bits. External row handshake is ignored and row_ready stays 0.
//   - Finishes after ROWS cycles with the normal load_done pulse.
//  RANDOM_SEED_EN undefined: no rand_fill port, no LFSR; behaviour exactly as above.
// STRUCTURE
//  - Shared package life_pkg: state enum (IDLE, LOAD, RUN), LIFE_ROWS and LIFE_COLS
//    constants, LFSR reset seed and tap constant.
//  - One sub-module: step_timer (down-counter with reload; emits the tick).
//    FSM and board register stay in the top level.
// TESTING
//  1. Reset: assert rst_n=0 mid-cycle -> board_out=0, row_ready=0, step_en=0 immediately.
//  2. Load: load_start, then rows 16'h0001..16'h0010 with valid gaps ->
//     board_out[15:0]=16'h0001, board_out[255:240]=16'h0010; load_done exactly once; state IDLE.
//  3. Backpressure/ignore: during LOAD assert run and single_step ->
//     no step_en; after load_done with run still high -> RUN.
//  4. Run timing, STEP_CYCLES=4: run=1 for 20 cycles -> step_en pulses on cycles 4,8,12,16,20
//     after entry. Drop run on cycle 10 -> no further pulses.
//  5. Priority: load_start and single_step on the same IDLE cycle -> LOAD entered, no step_en.
//     Later single_step alone -> exactly one step_en.
//  6. RANDOM_SEED_EN build: rand_fill -> 16 consecutive LFSR rows in board_out,
//     load_done at cycle 17, row_ready low throughout.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and constants for the 16x16 life engine front end.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int          LIFE_ROWS = 16;
  localparam int          LIFE_COLS = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 as a bit mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/board_seed_sequencer_step_timer.sv
// Step period down-counter: holds its reload value while disabled and
// emits a one-cycle tick each time it expires while enabled.
module step_timer
  import life_pkg::*;
#(
  parameter int STEP_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int             TW     = $clog2(STEP_CYCLES);
  localparam logic [TW-1:0]  RELOAD = TW'(STEP_CYCLES - 1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RELOAD;
    end else if (!en || cnt_q == '0) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/board_seed_sequencer.sv
// Seed loader and step sequencer for the life engine.
// Optional RANDOM_SEED_EN adds rand_fill: an LFSR-sourced board fill.
module board_seed_sequencer
  import life_pkg::*;
#(
  parameter int ROWS        = LIFE_ROWS,
  parameter int COLS        = LIFE_COLS,
  parameter int STEP_CYCLES = 25_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 row_valid,
  output logic                 row_ready,
  input  logic [COLS-1:0]      row_data,
  input  logic                 run,
  input  logic                 single_step,
`ifdef RANDOM_SEED_EN
  input  logic                 rand_fill,
`endif
  output logic [ROWS*COLS-1:0] board_out,
  output logic                 step_en,
  output logic                 load_done,
  output logic                 busy
);

  localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t          state_q, state_d;
  logic [RIW-1:0]  row_idx_q;
  logic            timer_en, tick;
  logic            step_d, ready_d;
  logic            wr_row, last_row;
  logic [COLS-1:0] wr_data;
  logic            fill_start, fill_sel, fill_next;
  logic [COLS-1:0] fill_row;

`ifdef RANDOM_SEED_EN
  logic [15:0] lfsr_q;
  logic        fill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
      fill_q <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
      fill_q <= fill_next;
    end
  end

  assign fill_start = (state_q == IDLE) && !load_start && rand_fill;
  assign fill_sel   = fill_q;
  assign fill_row   = lfsr_q[COLS-1:0];
`else
  assign fill_start = 1'b0;
  assign fill_sel   = 1'b0;
  assign fill_row   = '0;
`endif

  step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_step_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (timer_en),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    timer_en = 1'b0;
    step_d   = 1'b0;
    wr_row   = 1'b0;
    wr_data  = fill_sel ? fill_row : row_data;
    case (state_q)
      IDLE: begin
        if (load_start)       state_d = LOAD;
        else if (fill_start)  state_d = LOAD;
        else if (run)         state_d = RUN;
        else if (single_step) step_d  = 1'b1;
      end
      LOAD: begin
        wr_row = fill_sel || (row_valid && row_ready);
        if (wr_row && row_idx_q == RIW'(ROWS - 1)) state_d = IDLE;
      end
      RUN: begin
        // Leaving RUN keeps the timer disabled, so it reloads and no pulse escapes
        if (load_start)  state_d = LOAD;
        else if (!run)   state_d = IDLE;
        else begin
          timer_en = 1'b1;
          step_d   = tick;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign last_row  = wr_row && (row_idx_q == RIW'(ROWS - 1));
  assign fill_next = fill_start || (fill_sel && state_q == LOAD && state_d == LOAD);
  assign ready_d   = (state_d == LOAD) && !fill_next;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_idx_q <= '0;
      row_ready <= 1'b0;
      step_en   <= 1'b0;
      load_done <= 1'b0;
      board_out <= '0;
    end else begin
      state_q   <= state_d;
      row_ready <= ready_d;
      step_en   <= step_d;
      load_done <= last_row;
      if (wr_row) begin
        board_out[int'(row_idx_q)*COLS +: COLS] <= wr_data;
        row_idx_q <= last_row ? '0 : row_idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_board_seed_sequencer.sv
// Scoreboard bench for board_seed_sequencer (STEP_CYCLES=4); covers the
// rand_fill path too when RANDOM_SEED_EN is defined.
module tb_board_seed_sequencer;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int S    = 4;
  localparam int BW   = ROWS * COLS;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load_start = 1'b0;
  logic            row_valid = 1'b0;
  logic            row_ready;
  logic [COLS-1:0] row_data = '0;
  logic            run = 1'b0;
  logic            single_step = 1'b0;
  logic [BW-1:0]   board_out;
  logic            step_en, load_done, busy;
`ifdef RANDOM_SEED_EN
  logic            rand_fill = 1'b0;
`endif

  board_seed_sequencer #(.ROWS(ROWS), .COLS(COLS), .STEP_CYCLES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_data   (row_data),
    .run        (run),
    .single_step(single_step),
`ifdef RANDOM_SEED_EN
    .rand_fill  (rand_fill),
`endif
    .board_out  (board_out),
    .step_en    (step_en),
    .load_done  (load_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected cycle of each step_en / load_done, plus board at load_done
  int            step_q[$];
  int            done_q[$];
  logic [BW-1:0] board_q[$];
  logic [COLS-1:0] model_rows [ROWS];
  int            mon_cyc;
  logic [BW-1:0] mon_board;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] model_board();
    logic [BW-1:0] f;
    for (int r = 0; r < ROWS; r++) f[r*COLS +: COLS] = model_rows[r];
    return f;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (step_en) begin
        if (step_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected step_en: at cycle %0d, none expected", cyc);
        end else begin
          mon_cyc = step_q.pop_front();
          check("step_en cycle", cyc, mon_cyc);
          check("step_en outside LOAD", row_ready, 1'b0);
        end
      end
      if (load_done) begin
        if (done_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected load_done: at cycle %0d, none expected", cyc);
        end else begin
          mon_cyc   = done_q.pop_front();
          mon_board = board_q.pop_front();
          check("load_done cycle", cyc, mon_cyc);
          check("board_out at load_done", board_out, mon_board);
          check("idle after load", {row_ready, busy}, 2'b00);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drained(input string name);
    check({name, " step queue drained"}, step_q.size(), 0);
    check({name, " done queue drained"}, done_q.size(), 0);
  endtask

  // Predict run pulses: run entered on edge entry, held high through edge last
  task automatic expect_run(input int entry, input int last);
    for (int k = 1; entry + k*S <= last; k++) step_q.push_back(entry + k*S);
  endtask

  task automatic do_run(input int hold);
    int c;
    c = cyc;
    run = 1'b1;
    expect_run(c + 1, c + hold);
    tick(hold);
    check("busy in RUN", busy, 1'b1);
    run = 1'b0;
    tick(S + 2);
    check("busy after RUN", busy, 1'b0);
    drained("run");
  endtask

  // Load from IDLE; noise pokes run/single_step/load_start inside LOAD.
  // run_after>0 keeps run high so RUN follows the load.
  task automatic do_load(input logic fixed, input logic noise, input logic prio, input int run_after);
    logic acc;
    int   guard;
    load_start  = 1'b1;
    single_step = prio;
    if (run_after > 0) run = 1'b1;
    tick(1);
    load_start  = 1'b0;
    single_step = 1'b0;
    check("row_ready in LOAD", {row_ready, busy}, 2'b11);
    for (int r = 0; r < ROWS; r++) begin
      row_valid = 1'b0;
      tick($urandom_range(0, 2));
      if (noise && r == 5) begin
        single_step = 1'b1;
        load_start  = 1'b1;
        run         = 1'b1;
        tick(1);
        single_step = 1'b0;
        load_start  = 1'b0;
        if (run_after == 0) run = 1'b0;
      end
      row_valid = 1'b1;
      row_data  = fixed ? COLS'(r + 1) : COLS'($urandom);
      guard = 0;
      acc   = 1'b0;
      while (!acc) begin
        @(negedge clk);
        acc = row_ready;
        if (acc) begin
          model_rows[r] = row_data;
          if (r == ROWS - 1) begin
            done_q.push_back(cyc + 1);
            board_q.push_back(model_board());
          end
        end
        @(posedge clk); #1;
        guard++;
        if (guard > 50) begin
          $display("FAIL row handshake timeout: row %0d, row_ready stuck at %0b", r, row_ready);
          $fatal(1, "stalled");
        end
      end
    end
    row_valid = 1'b0;
    if (run_after > 0) begin
      expect_run(cyc + 1, cyc + run_after);
      tick(run_after);
      run = 1'b0;
    end
    tick(S + 2);
    drained("load");
  endtask

  task automatic do_single();
    single_step = 1'b1;
    step_q.push_back(cyc + 1);
    tick(1);
    single_step = 1'b0;
    tick(3);
    drained("single_step");
  endtask

  task automatic do_reset_mid_load();
    load_start = 1'b1;
    tick(1);
    load_start = 1'b0;
    row_valid  = 1'b1;
    row_data   = 16'hBEEF;
    tick(3);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset clears board", board_out, '0);
    check("reset clears outputs", {row_ready, step_en, load_done, busy}, 4'b0000);
    row_valid = 1'b0;
    for (int r = 0; r < ROWS; r++) model_rows[r] = '0;
    step_q.delete(); done_q.delete(); board_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
  endtask

`ifdef RANDOM_SEED_EN
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic do_rand_fill();
    int          c;
    logic [15:0] v;
    c = cyc;
    rand_fill = 1'b1;
    tick(1);
    rand_fill = 1'b0;
    v = m_lfsr;
    for (int r = 0; r < ROWS; r++) begin
      model_rows[r] = v[COLS-1:0];
      v = lfsr_step(v);
    end
    done_q.push_back(c + ROWS + 1);
    board_q.push_back(model_board());
    repeat (ROWS + 1) begin
      @(negedge clk);
      check("row_ready low in fill", row_ready, 1'b0);
    end
    tick(3);
    drained("rand_fill");
  endtask
`endif

  initial begin
    for (int r = 0; r < ROWS; r++) model_rows[r] = '0;
    #12;
    check("reset board_out", board_out, '0);
    check("reset outputs", {row_ready, step_en, load_done, busy}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    check("idle after reset", {row_ready, step_en, load_done, busy}, 4'b0000);

    do_load(1'b1, 1'b0, 1'b0, 0);
    check("row 0 of counting seed", board_out[15:0], 16'h0001);
    check("row 15 of counting seed", board_out[255:240], 16'h0010);

    do_load(1'b0, 1'b1, 1'b0, 9);
    do_run(21);
    do_run(10);
    do_load(1'b0, 1'b0, 1'b1, 0);
    do_single();
    // load_start in RUN aborts the run; RUN resumes after the load
    run = 1'b1;
    expect_run(cyc + 1, cyc + 7);
    tick(7);
    do_load(1'b0, 1'b0, 1'b0, 6);
    repeat (4) do_run($urandom_range(1, 30));
    repeat (2) begin
      do_load(1'b0, 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 12));
      do_single();
    end
`ifdef RANDOM_SEED_EN
    do_rand_fill();
`endif
    do_reset_mid_load();
    do_load(1'b0, 1'b0, 1'b0, 0);
    do_single();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
